check_clean_design: RTL and testbench

Parametrised successor test vehicle for the `check` pass flow. Every construct that is a deliberate check failure in the original design (multiple drivers, combinational loops, undriven nets) is rebuilt here as legal sequential logic, generalised to WIDTH bits and NUM_SRC sources. Synthesis plus `check -assert` must pass clean on this design. It is used as a positive regression alongside the failing design.

---
 rtl/check_clean_design.sv | 113 +++++++++++
 tb/tb_check_clean_design.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/check_clean_design.sv
`default_nettype none
// check_clean_design: round-robin arbiter, priority select, toggle, counter,
// hold register and delay line, all built as single-driver loop-free logic.
module check_clean_design #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 4,
  parameter int DELAY   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic [WIDTH-1:0]         z0,
  output logic                     z0_valid,
  output logic [WIDTH-1:0]         z1,
  input  logic                     tog_en,
  output logic                     z2,
  output logic [CNT_W-1:0]         z3,
  input  logic                     hold_load,
  input  logic [WIDTH-1:0]         hold_data,
  output logic [WIDTH-1:0]         z4,
  output logic [WIDTH-1:0]         z5,
  output logic [WIDTH-1:0]         z6
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_SRC - 1);

  logic [PTR_W-1:0]   ptr_q;
  logic [WIDTH-1:0]   z0_q;
  logic               z0_valid_q;
  logic               z2_q;
  logic [CNT_W-1:0]   z3_q;
  logic [WIDTH-1:0]   hold_q;
  logic [WIDTH-1:0]   pipe_q [DELAY];

  logic [NUM_SRC-1:0] grant_d;
  logic               found_d;
  logic [PTR_W-1:0]   win_idx_d;
  logic [WIDTH-1:0]   win_data_d;
  logic [WIDTH-1:0]   z1_d;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    grant_d    = '0;
    found_d    = 1'b0;
    win_idx_d  = '0;
    win_data_d = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found_d && src_valid[idx]) begin
        found_d      = 1'b1;
        grant_d[idx] = 1'b1;
        win_idx_d    = PTR_W'(idx);
        win_data_d   = src_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    z1_d = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) z1_d = src_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= PTR_RST;
      z0_q       <= '0;
      z0_valid_q <= 1'b0;
      z2_q       <= 1'b0;
      z3_q       <= '0;
      hold_q     <= '0;
    end else begin
      z0_valid_q <= found_d;
      if (found_d) begin
        z0_q  <= win_data_d;
        ptr_q <= win_idx_d;
      end
      z2_q <= ~z2_q & tog_en;
      z3_q <= z3_q + 1'b1;
      if (hold_load) hold_q <= hold_data;
    end
  end

  // Delay line on source 0 data, sampled regardless of its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DELAY; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= src_data[WIDTH-1:0];
      for (int s = 1; s < DELAY; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign src_ready = reset ? '0 : grant_d;
  assign z0        = z0_q;
  assign z0_valid  = z0_valid_q;
  assign z1        = z1_d;
  assign z2        = z2_q;
  assign z3        = z3_q;
  assign z4        = hold_q | z1_d;
  assign z5        = hold_q & z1_d;
  assign z6        = pipe_q[DELAY-1];

endmodule
`default_nettype wire

// File: tb/tb_check_clean_design.sv
`default_nettype none
// tb_check_clean_design: directed checks of arbiter, toggle, counter, hold and delay line.
module tb_check_clean_design;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  src_valid;
  logic [15:0] src_data;
  logic [1:0]  src_ready;
  logic [7:0]  z0;
  logic        z0_valid;
  logic [7:0]  z1;
  logic        tog_en;
  logic        z2;
  logic [3:0]  z3;
  logic        hold_load;
  logic [7:0]  hold_data;
  logic [7:0]  z4;
  logic [7:0]  z5;
  logic [7:0]  z6;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_z3 = 4'd0;

  check_clean_design #(.WIDTH(8), .NUM_SRC(2), .CNT_W(4), .DELAY(2)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .z0(z0), .z0_valid(z0_valid), .z1(z1),
    .tog_en(tog_en), .z2(z2), .z3(z3), .hold_load(hold_load),
    .hold_data(hold_data), .z4(z4), .z5(z5), .z6(z6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the counter model follows reset sampled at the edge.
  task automatic tick();
    @(posedge clk);
    exp_z3 = reset ? 4'd0 : exp_z3 + 4'd1;
    #1;
  endtask

  initial begin
    reset = 1'b1; src_valid = 2'b00; src_data = 16'h0000;
    tog_en = 1'b0; hold_load = 1'b0; hold_data = 8'h00;
    tick(); tick();
    chk("rst_z0", z0, 8'h00);
    chk("rst_z0v", z0_valid, 1'b0);
    chk("rst_z2", z2, 1'b0);
    chk("rst_z3", z3, 4'd0);
    chk("rst_z4", z4, 8'h00);
    chk("rst_z5", z5, 8'h00);
    chk("rst_rdy", src_ready, 2'b00);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("z3_count", z3, i);
    end

    // Both sources valid: grants alternate starting with source 0.
    src_data = {8'h22, 8'h11}; src_valid = 2'b11; #1;
    chk("rr_rdy0", src_ready, 2'b01);
    chk("rr_z1", z1, 8'h11);
    tick(); chk("rr_z0a", z0, 8'h11); chk("rr_v", z0_valid, 1'b1); chk("rr_rdy1", src_ready, 2'b10);
    tick(); chk("rr_z0b", z0, 8'h22); chk("rr_rdy2", src_ready, 2'b01); chk("rr_z1b", z1, 8'h11);
    tick(); chk("rr_z0c", z0, 8'h11); chk("rr_rdy3", src_ready, 2'b10);
    tick(); chk("rr_z0d", z0, 8'h22); chk("rr_v2", z0_valid, 1'b1);

    // Only source 1 valid for three cycles, then none.
    src_data = {8'h5A, 8'h00}; src_valid = 2'b10; #1;
    for (int i = 0; i < 3; i++) begin
      chk("s1_rdy", src_ready, 2'b10);
      chk("s1_z1", z1, 8'h5A);
      tick();
      chk("s1_z0", z0, 8'h5A);
      chk("s1_v", z0_valid, 1'b1);
    end
    src_valid = 2'b00; #1;
    chk("idle_rdy", src_ready, 2'b00);
    chk("idle_z1", z1, 8'h00);
    tick(); chk("idle_v", z0_valid, 1'b0); chk("idle_hold", z0, 8'h5A);
    tick(); chk("idle_v2", z0_valid, 1'b0); chk("z3_model", z3, exp_z3);

    // Toggle sequence, then forced low.
    tog_en = 1'b1;
    tick(); chk("tog1", z2, 1'b1);
    tick(); chk("tog2", z2, 1'b0);
    tick(); chk("tog3", z2, 1'b1);
    tick(); chk("tog4", z2, 1'b0);
    tick(); chk("tog5", z2, 1'b1);
    tog_en = 1'b0;
    tick(); chk("tog_off", z2, 1'b0);
    tick(); chk("tog_off2", z2, 1'b0);

    // Counter wrap 15 -> 0.
    for (int i = 0; i < 16 && exp_z3 != 4'd15; i++) tick();
    chk("z3_at15", z3, 4'd15);
    tick(); chk("z3_wrap", z3, 4'd0);
    tick(); chk("z3_after", z3, 4'd1);

    // Hold register and delay line.
    hold_load = 1'b1; hold_data = 8'hF0;
    src_data = {8'h00, 8'h3C}; src_valid = 2'b01; #1;
    chk("z6_pre", z6, 8'h00);
    tick();
    hold_load = 1'b0; hold_data = 8'h00; #1;
    chk("hold_z4", z4, 8'hFC);
    chk("hold_z5", z5, 8'h30);
    chk("z6_d1", z6, 8'h00);
    chk("s0_z0", z0, 8'h3C);
    tick();
    chk("z6_d2", z6, 8'h3C);
    chk("hold_kept", z4, 8'hFC);

    // Mid-stream reset after a grant to source 0.
    reset = 1'b1; src_valid = 2'b11; src_data = {8'h22, 8'h11}; #1;
    chk("mr_rdy_rst", src_ready, 2'b00);
    tick();
    chk("mr_z0", z0, 8'h00);
    chk("mr_v", z0_valid, 1'b0);
    chk("mr_z6", z6, 8'h00);
    chk("mr_z4", z4, 8'h11);
    chk("mr_z3", z3, 4'd0);
    reset = 1'b0; #1;
    chk("mr_rdy", src_ready, 2'b01);
    tick();
    chk("mr_z0g", z0, 8'h11);
    chk("mr_vg", z0_valid, 1'b1);
    chk("mr_rdy2", src_ready, 2'b10);
    chk("mr_z3b", z3, exp_z3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
